// File: rtl/imem_uart_loader.sv
// UART (8N1) program loader: receives a length-prefixed stream of
// 32-bit words and writes them into instruction memory.
module imem_uart_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        RxD,
    output logic        WrEn,
    output logic [31:0] WrAddress,
    output logic [31:0] WrData,
    output logic        Loading,
    output logic        Done,
    output logic        FrameErr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        L_CNT_HI,
        L_CNT_LO,
        L_DATA,
        L_WRITE,
        L_DONE
    } ld_state_t;

    logic rx_meta;
    logic rx_sync;

    rx_state_t        rx_state, rx_state_n;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]       rx_bit, rx_bit_n;
    logic [7:0]       rx_shift, rx_shift_n;
    logic             byte_valid;
    logic             frame_err_p;

    ld_state_t             ld_state, ld_state_n;
    logic [7:0]            cnt_hi, cnt_hi_n;
    logic [15:0]           remain, remain_n;
    logic [23:0]           word, word_n;
    logic [1:0]            byte_idx, byte_idx_n;
    logic [ADDR_WIDTH-1:0] addr_cnt, addr_cnt_n;
    logic [31:0]           wr_addr_n, wr_data_n;
    logic                  loading_n, done_n, frame_err_n;

    // Two-flop synchronizer for the asynchronous serial line (idles high)
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= RxD;
            rx_sync <= rx_meta;
        end
    end

    // Receiver state register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    // Receiver next state: mid-bit sampling, LSB first, stop bit check
    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = rx_cnt;
        rx_bit_n    = rx_bit;
        rx_shift_n  = rx_shift;
        byte_valid  = 1'b0;
        frame_err_p = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                rx_bit_n = '0;
                if (!rx_sync) rx_state_n = RX_START;
            end
            RX_START: begin
                if (rx_cnt == HALF_M1) begin
                    rx_cnt_n   = '0;
                    rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt == FULL_M1) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_sync, rx_shift[7:1]};
                    rx_bit_n   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == FULL_M1) begin
                    rx_cnt_n    = '0;
                    byte_valid  = rx_sync;
                    frame_err_p = !rx_sync;
                    rx_state_n  = RX_IDLE;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // Loader state and output registers
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ld_state  <= L_CNT_HI;
            cnt_hi    <= '0;
            remain    <= '0;
            word      <= '0;
            byte_idx  <= '0;
            addr_cnt  <= '0;
            WrAddress <= '0;
            WrData    <= '0;
            Loading   <= 1'b0;
            Done      <= 1'b0;
            FrameErr  <= 1'b0;
        end else begin
            ld_state  <= ld_state_n;
            cnt_hi    <= cnt_hi_n;
            remain    <= remain_n;
            word      <= word_n;
            byte_idx  <= byte_idx_n;
            addr_cnt  <= addr_cnt_n;
            WrAddress <= wr_addr_n;
            WrData    <= wr_data_n;
            Loading   <= loading_n;
            Done      <= done_n;
            FrameErr  <= frame_err_n;
        end
    end

    // Loader next state: parse count, assemble big-endian words, write
    always_comb begin
        ld_state_n  = ld_state;
        cnt_hi_n    = cnt_hi;
        remain_n    = remain;
        word_n      = word;
        byte_idx_n  = byte_idx;
        addr_cnt_n  = addr_cnt;
        wr_addr_n   = WrAddress;
        wr_data_n   = WrData;
        loading_n   = Loading;
        done_n      = Done;
        frame_err_n = FrameErr | frame_err_p;
        unique case (ld_state)
            L_CNT_HI, L_DONE: begin
                if (byte_valid) begin
                    cnt_hi_n   = rx_shift;
                    loading_n  = 1'b1;
                    done_n     = 1'b0;
                    addr_cnt_n = '0;
                    ld_state_n = L_CNT_LO;
                end
            end
            L_CNT_LO: begin
                if (byte_valid) begin
                    if ({cnt_hi, rx_shift} == 16'd0) begin
                        done_n     = 1'b1;
                        loading_n  = 1'b0;
                        ld_state_n = L_DONE;
                    end else begin
                        remain_n   = {cnt_hi, rx_shift};
                        byte_idx_n = '0;
                        ld_state_n = L_DATA;
                    end
                end
            end
            L_DATA: begin
                if (byte_valid) begin
                    word_n     = {word[15:0], rx_shift};
                    byte_idx_n = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        wr_data_n  = {word, rx_shift};
                        wr_addr_n  = 32'({addr_cnt, 2'b00});
                        ld_state_n = L_WRITE;
                    end
                end
            end
            L_WRITE: begin
                addr_cnt_n = addr_cnt + 1'b1;
                remain_n   = remain - 16'd1;
                if (remain == 16'd1) begin
                    done_n     = 1'b1;
                    loading_n  = 1'b0;
                    ld_state_n = L_DONE;
                end else begin
                    ld_state_n = L_DATA;
                end
            end
            default: ld_state_n = L_CNT_HI;
        endcase
        // A bad stop bit aborts any load in progress
        if (frame_err_p && ld_state != L_DONE) begin
            loading_n  = 1'b0;
            ld_state_n = L_CNT_HI;
        end
    end

    assign WrEn = (ld_state == L_WRITE);

endmodule

// File: tb/tb_imem_uart_loader.sv
// Self-checking bench for imem_uart_loader: directed and random
// streams checked against a stream-level reference model.
module tb_imem_uart_loader;

    localparam int CPB = 16;
    localparam int AW1 = 10;
    localparam int AW2 = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic        we1, ld1, dn1, fe1;
    logic        we2, ld2, dn2, fe2;
    logic [31:0] a1, d1, a2, d2;

    logic [63:0] cap1[$];
    logic [63:0] cap2[$];
    logic [63:0] exp1[$];
    logic [63:0] exp2[$];
    logic [7:0]  q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW1)) u1 (
        .Clk(clk), .Rst(rst), .RxD(rxd), .WrEn(we1), .WrAddress(a1),
        .WrData(d1), .Loading(ld1), .Done(dn1), .FrameErr(fe1)
    );

    imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW2)) u2 (
        .Clk(clk), .Rst(rst), .RxD(rxd), .WrEn(we2), .WrAddress(a2),
        .WrData(d2), .Loading(ld2), .Done(dn2), .FrameErr(fe2)
    );

    // Record every write strobe (one entry per high cycle)
    always @(negedge clk) begin
        if (we1) cap1.push_back({a1, d1});
        if (we2) cap2.push_back({a2, d2});
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: a stream is a 16-bit count then big-endian words,
    // written to consecutive word addresses wrapping at the depth.
    task automatic model_load(input logic [7:0] b[$]);
        int          n;
        logic [31:0] w;
        n = int'({b[0], b[1]});
        for (int i = 0; i < n; i++) begin
            w = {b[2+4*i], b[3+4*i], b[4+4*i], b[5+4*i]};
            exp1.push_back({32'((i % (1 << AW1)) * 4), w});
            exp2.push_back({32'((i % (1 << AW2)) * 4), w});
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok,
                             input int gap);
        @(negedge clk) rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_ok;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_stream(input logic [7:0] b[$], input int maxgap);
        model_load(b);
        for (int i = 0; i < b.size(); i++)
            send_byte(b[i], 1'b1, int'($urandom_range(0, maxgap)));
        repeat (20) @(negedge clk);
    endtask

    task automatic check_writes(input string tag);
        int m;
        chk({tag, "_count1"}, 64'(cap1.size()), 64'(exp1.size()));
        m = (cap1.size() < exp1.size()) ? cap1.size() : exp1.size();
        for (int i = 0; i < m; i++)
            chk({tag, "_write1"}, cap1[i], exp1[i]);
        chk({tag, "_count2"}, 64'(cap2.size()), 64'(exp2.size()));
        m = (cap2.size() < exp2.size()) ? cap2.size() : exp2.size();
        for (int i = 0; i < m; i++)
            chk({tag, "_write2"}, cap2[i], exp2[i]);
        cap1.delete();
        cap2.delete();
        exp1.delete();
        exp2.delete();
    endtask

    initial begin
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_flags", 64'({we1, ld1, dn1, fe1, we2, ld2, dn2, fe2}), 64'd0);
        chk("rst_addr", {a1, a2}, 64'd0);
        chk("rst_data", {d1, d2}, 64'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Short low glitch: no byte, loader stays idle
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_flags", 64'({ld1, dn1, fe1}), 64'd0);
        check_writes("glitch");

        // Asynchronous reset in the middle of a data byte
        send_byte(8'h00, 1'b1, 2);
        send_byte(8'h01, 1'b1, 2);
        @(negedge clk) rxd = 1'b0;
        repeat (CPB * 3) @(negedge clk);
        chk("pre_rst_loading", 64'(ld1), 64'd1);
        #2 rst = 1'b1;
        #1 chk("async_rst", 64'({we1, ld1, dn1, fe1, ld2}), 64'd0);
        @(negedge clk);
        rxd = 1'b1;
        rst = 1'b0;
        repeat (CPB * 12) @(negedge clk);
        check_writes("rst_discard");

        // Two-word image
        q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
              8'h8C, 8'h01, 8'h00, 8'h04};
        send_stream(q, 10);
        check_writes("two_words");
        chk("two_words_status", 64'({dn1, ld1, fe1}), 64'b100);

        // Empty image
        send_byte(8'h00, 1'b1, 4);
        chk("empty_loading", 64'({ld1, dn1}), 64'b10);
        send_byte(8'h00, 1'b1, 20);
        chk("empty_done", 64'({ld1, dn1}), 64'b01);
        check_writes("empty");

        // Framing error mid-image, then a clean image
        send_byte(8'h00, 1'b1, 3);
        send_byte(8'h01, 1'b1, 3);
        send_byte(8'h12, 1'b1, 3);
        send_byte(8'h34, 1'b1, 3);
        send_byte(8'($urandom), 1'b0, 30);
        chk("ferr_flags", 64'({fe1, ld1, dn1, fe2}), 64'b1001);
        check_writes("ferr_none");
        q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_stream(q, 6);
        check_writes("after_ferr");
        chk("after_ferr_status", 64'({dn1, ld1, fe1}), 64'b101);

        // Five words: the shallow instance wraps its address
        q = '{8'h00, 8'h05};
        for (int i = 1; i <= 5; i++) begin
            q.push_back(8'h00);
            q.push_back(8'h00);
            q.push_back(8'h00);
            q.push_back(8'(i));
        end
        send_stream(q, 4);
        check_writes("wrap");
        chk("wrap_status", 64'({dn2, ld2, dn1, ld1}), 64'b1010);

        // Random images with random idle gaps
        for (int r = 0; r < 8; r++) begin
            n = int'($urandom_range(1, 6));
            q = '{8'(n >> 8), 8'(n)};
            for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
            send_stream(q, 12);
            check_writes("random");
            chk("random_status", 64'({dn1, ld1, dn2, ld2}), 64'b1010);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
